// File: rtl/ace_ccu_conflict_tracker_if.sv
// Snoop request and per-port completion bus of the conflict tracker.
// The slave side is the tracker and the master side is the snoop path.
interface ace_ccu_conflict_tracker_if #(
    parameter int unsigned CmAddrWidth = 32,
    parameter int unsigned NoRespPorts = 2
);
    logic                                   snoop_valid_i;
    logic                                   snoop_ready_i;
    logic [CmAddrWidth-1:0]                 snoop_addr_i;
    logic [NoRespPorts-1:0]                 snoop_targets_i;
    logic                                   snoop_stall_o;
    logic [NoRespPorts-1:0]                 x_req_i;
    logic [NoRespPorts-1:0][CmAddrWidth-1:0] x_addr_i;

    modport slave (
        input  snoop_valid_i, snoop_ready_i, snoop_addr_i, snoop_targets_i,
        input  x_req_i, x_addr_i,
        output snoop_stall_o
    );

    modport master (
        output snoop_valid_i, snoop_ready_i, snoop_addr_i, snoop_targets_i,
        output x_req_i, x_addr_i,
        input  snoop_stall_o
    );
endinterface

// File: rtl/ace_ccu_conflict_tracker.sv
// Set-associative table of outstanding snoop addresses. A new snoop is stalled
// while its address is outstanding or its set is full.
module ace_ccu_conflict_tracker #(
    parameter int unsigned CmAddrWidth = 32,
    parameter int unsigned IdxWidth    = 4,
    parameter int unsigned NumWays     = 2,
    parameter int unsigned NoRespPorts = 2,
    parameter int unsigned OccWidth    = $clog2(NumWays * 2**IdxWidth + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    ace_ccu_conflict_tracker_if.slave  bus,
    input  logic                       flush_i,
    output logic [OccWidth-1:0]        occupancy_o,
    output logic                       busy_o
);
    localparam int unsigned NumSets  = 2**IdxWidth;
    localparam int unsigned TagWidth = CmAddrWidth - IdxWidth;
    localparam int unsigned WayWidth = (NumWays > 1) ? $clog2(NumWays) : 1;

    typedef logic [TagWidth-1:0]    tag_t;
    typedef logic [NoRespPorts-1:0] pend_t;

    tag_t                r_tag  [NumWays][NumSets];
    pend_t               r_pend [NumWays][NumSets];
    logic [OccWidth-1:0] r_occ;

    pend_t               w_pend_nxt [NumWays][NumSets];
    logic [OccWidth-1:0] w_occ_nxt;
    logic [IdxWidth-1:0] w_idx;
    tag_t                w_tag;
    logic                w_hit;
    logic                w_full;
    logic [WayWidth-1:0] w_free_way;
    logic                w_has_targets;
    logic                w_accept;

    function automatic logic [IdxWidth-1:0] f_idx(input logic [CmAddrWidth-1:0] a);
        return a[IdxWidth-1:0];
    endfunction

    function automatic tag_t f_tag(input logic [CmAddrWidth-1:0] a);
        return a[CmAddrWidth-1:IdxWidth];
    endfunction

    // Scan downwards so the lowest-index free way wins.
    always_comb begin
        w_idx      = f_idx(bus.snoop_addr_i);
        w_tag      = f_tag(bus.snoop_addr_i);
        w_hit      = 1'b0;
        w_full     = 1'b1;
        w_free_way = '0;
        for (int w = int'(NumWays) - 1; w >= 0; w--) begin
            if (|r_pend[w][w_idx]) begin
                if (r_tag[w][w_idx] == w_tag) w_hit = 1'b1;
            end else begin
                w_full     = 1'b0;
                w_free_way = WayWidth'(w);
            end
        end
    end

    assign w_has_targets     = |bus.snoop_targets_i;
    assign bus.snoop_stall_o = bus.snoop_valid_i &&
                               (flush_i || (w_has_targets && (w_hit || w_full)));
    assign w_accept          = bus.snoop_valid_i && bus.snoop_ready_i &&
                               !bus.snoop_stall_o && w_has_targets;

    // Clears match only registered entries, so a same-cycle allocation is never hit.
    always_comb begin
        w_pend_nxt = r_pend;
        for (int r = 0; r < int'(NoRespPorts); r++) begin
            if (bus.x_req_i[r]) begin
                for (int w = 0; w < int'(NumWays); w++) begin
                    if ((|r_pend[w][f_idx(bus.x_addr_i[r])]) &&
                        (r_tag[w][f_idx(bus.x_addr_i[r])] == f_tag(bus.x_addr_i[r])))
                        w_pend_nxt[w][f_idx(bus.x_addr_i[r])][r] = 1'b0;
                end
            end
        end
        if (w_accept) w_pend_nxt[w_free_way][w_idx] = bus.snoop_targets_i;
        if (flush_i) begin
            for (int w = 0; w < int'(NumWays); w++)
                for (int s = 0; s < int'(NumSets); s++)
                    w_pend_nxt[w][s] = '0;
        end
    end

    always_comb begin
        w_occ_nxt = '0;
        for (int w = 0; w < int'(NumWays); w++)
            for (int s = 0; s < int'(NumSets); s++)
                if (|w_pend_nxt[w][s]) w_occ_nxt = w_occ_nxt + OccWidth'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < int'(NumWays); w++)
                for (int s = 0; s < int'(NumSets); s++)
                    r_pend[w][s] <= '0;
            r_occ <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_occ  <= w_occ_nxt;
        end
    end

    // Tags are meaningless while pending is zero, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (w_accept) r_tag[w_free_way][w_idx] <= w_tag;
    end

    assign occupancy_o = r_occ;
    assign busy_o      = |r_occ;
endmodule

// File: tb/tb_ace_ccu_conflict_tracker.sv
// Drives two tracker geometries with shared stimulus and compares them against
// a bag-of-outstanding-addresses reference model.
module tb_ace_ccu_conflict_tracker;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s_valid, s_ready, flush;
    logic [31:0] s_addr;
    logic [2:0]  s_tgt, s_xreq;
    logic [31:0] s_xaddr [3];
    logic [5:0]  occ_a;
    logic        busy_a;
    logic [4:0]  occ_b;
    logic        busy_b;

    ace_ccu_conflict_tracker_if #(.CmAddrWidth(32), .NoRespPorts(2)) ifa ();
    ace_ccu_conflict_tracker_if #(.CmAddrWidth(32), .NoRespPorts(3)) ifb ();

    assign ifa.snoop_valid_i   = s_valid;
    assign ifa.snoop_ready_i   = s_ready;
    assign ifa.snoop_addr_i    = s_addr;
    assign ifa.snoop_targets_i = s_tgt[1:0];
    assign ifa.x_req_i         = s_xreq[1:0];
    assign ifa.x_addr_i        = {s_xaddr[1], s_xaddr[0]};
    assign ifb.snoop_valid_i   = s_valid;
    assign ifb.snoop_ready_i   = s_ready;
    assign ifb.snoop_addr_i    = s_addr;
    assign ifb.snoop_targets_i = s_tgt;
    assign ifb.x_req_i         = s_xreq;
    assign ifb.x_addr_i        = {s_xaddr[2], s_xaddr[1], s_xaddr[0]};

    ace_ccu_conflict_tracker #(.CmAddrWidth(32), .IdxWidth(4), .NumWays(2), .NoRespPorts(2)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifa), .flush_i(flush),
        .occupancy_o(occ_a), .busy_o(busy_a));
    ace_ccu_conflict_tracker #(.CmAddrWidth(32), .IdxWidth(2), .NumWays(4), .NoRespPorts(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifb), .flush_i(flush),
        .occupancy_o(occ_b), .busy_o(busy_b));

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: each config keeps an unordered bag of outstanding snoops.
    logic [31:0] m_addr [2][64];
    logic [2:0]  m_pend [2][64];

    function automatic int ways_of(int c);
        return (c == 0) ? 2 : 4;
    endfunction
    function automatic logic [31:0] setmask(int c);
        return (c == 0) ? 32'hF : 32'h3;
    endfunction
    function automatic logic [2:0] pmask(int c);
        return (c == 0) ? 3'b011 : 3'b111;
    endfunction

    function automatic int m_count(int c);
        int n = 0;
        for (int i = 0; i < 64; i++) if (m_pend[c][i] != 0) n++;
        return n;
    endfunction

    function automatic bit m_stall(int c);
        logic [2:0] t;
        bit hit = 0;
        int in_set = 0;
        t = s_tgt & pmask(c);
        for (int i = 0; i < 64; i++) begin
            if (m_pend[c][i] != 0) begin
                if (m_addr[c][i] == s_addr) hit = 1;
                if ((m_addr[c][i] & setmask(c)) == (s_addr & setmask(c))) in_set++;
            end
        end
        return s_valid && (flush || (t != 0 && (hit || in_set >= ways_of(c))));
    endfunction

    task automatic m_clear_all();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 64; i++) m_pend[c][i] = 3'b000;
    endtask

    task automatic m_update(int c);
        logic [2:0] t, pm;
        bit acc;
        bit done;
        pm  = pmask(c);
        t   = s_tgt & pm;
        acc = s_valid && s_ready && !m_stall(c) && (t != 0);
        if (flush) begin
            for (int i = 0; i < 64; i++) m_pend[c][i] = 3'b000;
        end else begin
            for (int r = 0; r < 3; r++)
                if (s_xreq[r] && pm[r])
                    for (int i = 0; i < 64; i++)
                        if (m_pend[c][i] != 0 && m_addr[c][i] == s_xaddr[r])
                            m_pend[c][i][r] = 1'b0;
            if (acc) begin
                done = 0;
                for (int i = 0; i < 64; i++)
                    if (!done && m_pend[c][i] == 0) begin
                        m_addr[c][i] = s_addr;
                        m_pend[c][i] = t;
                        done = 1;
                    end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Called at a falling edge; applies inputs, checks, and advances one cycle.
    task automatic step(input logic v, input logic rd, input logic [31:0] a, input logic [2:0] t,
                        input logic [2:0] xr, input logic [31:0] x0, input logic [31:0] x1,
                        input logic [31:0] x2, input logic fl);
        s_valid = v; s_ready = rd; s_addr = a; s_tgt = t; s_xreq = xr;
        s_xaddr[0] = x0; s_xaddr[1] = x1; s_xaddr[2] = x2; flush = fl;
        #1;
        chk("stall_a", ifa.snoop_stall_o, m_stall(0));
        chk("stall_b", ifb.snoop_stall_o, m_stall(1));
        chk("occ_a", occ_a, m_count(0));
        chk("occ_b", occ_b, m_count(1));
        chk("busy_a", busy_a, m_count(0) != 0);
        chk("busy_b", busy_b, m_count(1) != 0);
        @(posedge clk);
        m_update(0);
        m_update(1);
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_addr();
        int c, n, k;
        c = $urandom_range(0, 1);
        n = m_count(c);
        if (n == 0 || $urandom_range(0, 3) == 0) return 32'($urandom_range(0, 47));
        k = $urandom_range(0, n - 1);
        for (int i = 0; i < 64; i++)
            if (m_pend[c][i] != 0) begin
                if (k == 0) return m_addr[c][i];
                k--;
            end
        return 32'h0;
    endfunction

    initial begin
        rst_n = 1'b0;
        s_valid = 0; s_ready = 0; s_addr = 0; s_tgt = 0; s_xreq = 0; flush = 0;
        for (int i = 0; i < 3; i++) s_xaddr[i] = 0;
        m_clear_all();
        repeat (3) @(negedge clk);
        chk("rst_occ_a", occ_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_stall_a", ifa.snoop_stall_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Dual-target entry retires only after both ports complete.
        step(1, 1, 32'h13, 3'b011, 3'b000, 0, 0, 0, 0);
        step(1, 1, 32'h13, 3'b011, 3'b001, 32'h13, 0, 0, 0);
        step(1, 1, 32'h13, 3'b011, 3'b010, 0, 32'h13, 0, 0);
        step(1, 0, 32'h13, 3'b011, 3'b000, 0, 0, 0, 0);
        chk("s1_occ_a", occ_a, 0);

        // Set fill, set-full stall, retire then reuse.
        step(1, 1, 32'h13, 3'b001, 3'b000, 0, 0, 0, 0);
        step(1, 1, 32'h23, 3'b001, 3'b000, 0, 0, 0, 0);
        step(1, 1, 32'h33, 3'b001, 3'b000, 0, 0, 0, 0);
        chk("s2_occ_a", occ_a, 2);
        step(1, 1, 32'h14, 3'b001, 3'b000, 0, 0, 0, 0);
        step(0, 0, 32'h0, 3'b000, 3'b001, 32'h23, 0, 0, 0);
        step(1, 1, 32'h33, 3'b001, 3'b000, 0, 0, 0, 0);
        chk("s2_occ_a_end", occ_a, 3);

        // Flush with a pending snoop, then the same snoop goes through.
        step(1, 1, 32'h40, 3'b001, 3'b000, 0, 0, 0, 1);
        chk("flush_occ_a", occ_a, 0);
        step(1, 1, 32'h40, 3'b001, 3'b000, 0, 0, 0, 0);

        // Two ports retire two entries while a third allocates.
        step(1, 1, 32'h51, 3'b010, 3'b000, 0, 0, 0, 0);
        step(1, 1, 32'h62, 3'b001, 3'b011, 32'h40, 32'h51, 0, 0);
        chk("same_cycle_occ_a", occ_a, 1);

        // Zero-target snoop and spurious completion leave state alone.
        step(1, 1, 32'h62, 3'b000, 3'b001, 32'h55, 0, 0, 0);
        step(0, 0, 32'h0, 3'b000, 3'b000, 0, 0, 0, 1);

        // Asynchronous reset with live entries.
        step(1, 1, 32'h10, 3'b111, 3'b000, 0, 0, 0, 0);
        step(1, 1, 32'h11, 3'b111, 3'b000, 0, 0, 0, 0);
        step(1, 1, 32'h12, 3'b111, 3'b000, 0, 0, 0, 0);
        step(1, 1, 32'h13, 3'b111, 3'b000, 0, 0, 0, 0);
        step(1, 1, 32'h20, 3'b111, 3'b000, 0, 0, 0, 0);
        s_valid = 0; s_ready = 0; s_xreq = 0;
        #1;
        chk("pre_rst_occ_b", occ_b, 5);
        rst_n = 1'b0;
        #1;
        chk("async_rst_occ_b", occ_b, 0);
        chk("async_rst_busy_b", busy_b, 0);
        chk("async_rst_occ_a", occ_a, 0);
        m_clear_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 32'($urandom_range(0, 47)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), pick_addr(), pick_addr(), pick_addr(),
                 $urandom_range(0, 63) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ace_ccu_conflict_tracker.md
# ace_ccu_conflict_tracker

Parametrised address-conflict tracker for the ACE CCU snoop path. It records every accepted snoop address in a set-associative table, together with a per-responder pending mask. It stalls any new snoop to an address that is still outstanding, or whose set is full. Entries retire only after every targeted response port has reported completion, and the block adds flush, occupancy reporting and configurable geometry.

## Interface
Parameters:
- CmAddrWidth, 32, tracked address width; low IdxWidth bits are the set index, the rest is the tag
- IdxWidth, 4, set index width; NumSets = 2**IdxWidth; legal range 1..CmAddrWidth-1
- NumWays, 2, ways per set; legal values >= 1
- NoRespPorts, 2, number of response ports; legal values >= 1
- OccWidth, $clog2(NumWays*2**IdxWidth+1), occupancy counter width (derived)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- snoop_valid_i  in  1  snoop request present
- snoop_ready_i  in  1  downstream accepts snoop
- snoop_addr_i  in  CmAddrWidth  snoop address
- snoop_targets_i  in  NoRespPorts  ports expected to respond to this snoop
- snoop_stall_o  out  1  block snoop this cycle
- x_req_i  in  NoRespPorts  per-port completion strobe
- x_addr_i  in  NoRespPorts x CmAddrWidth  per-port completion address
- flush_i  in  1  invalidate all entries
- occupancy_o  out  OccWidth  number of valid entries (registered)
- busy_o  out  1  occupancy_o != 0

## Operation
- Entry per [way][set]: tag, pending[NoRespPorts]. An entry is valid iff |pending.
- Hit: snoop_valid_i, and some valid entry in set idx(snoop_addr_i) has an equal tag.
- Set full: no invalid way in set idx(snoop_addr_i).
- snoop_stall_o = snoop_valid_i && (flush_i || (snoop_targets_i != 0 && (hit || set full))). The output is 0 whenever snoop_valid_i = 0.
- A snoop with snoop_targets_i == 0 never stalls and never allocates.
- Accept = snoop_valid_i && snoop_ready_i && !snoop_stall_o && snoop_targets_i != 0.
  - On accept, write the lowest-index invalid way of the set with tag and pending = snoop_targets_i.
- Invariant: at most one valid entry per address, because a hit stalls.
- Completion: for each r with x_req_i[r], find a valid entry matching x_addr_i[r] and clear pending[r].
  - Completion strobes with no matching entry, or whose bit is already clear, are ignored and leave no state.
  - Several ports may clear bits of the same or different entries in the same cycle; all clears apply.
- All lookups (hit, set full, completion match, lowest free) use registered state only.
- A way freed this cycle is usable next cycle. An entry allocated this cycle cannot be cleared this cycle; a same-cycle strobe for it is lost, and responders must not complete before acceptance.
- flush_i: all entries are invalid next cycle. A flush overrides allocation and clears in that cycle.
- occupancy_o: registered popcount of valid entries, updated with the table. It never exceeds NumWays*NumSets.

## Timing
- Reset: all pending masks 0 (tags don't-care), occupancy_o = 0, busy_o = 0. snoop_stall_o is 0 while snoop_valid_i = 0.
- Reset mid-operation: every entry is dropped asynchronously; no completion survives.
- snoop_stall_o is combinational from snoop_valid_i, snoop_addr_i, snoop_targets_i, flush_i and the registered table. There is no path from snoop_ready_i or x_req_i.
- Allocation and retirement take effect one cycle after the edge; occupancy_o and busy_o reflect them in that same cycle.
- Back-to-back snoops to different sets: one accept per cycle, zero bubbles.
- Same address as the snoop accepted at edge N: stalled from cycle N+1 until the cycle after its last pending bit clears.

## Test plan
- Defaults. Accept addr 0x13 with targets 0b11. Then addr 0x13 -> stall=1. x_req[0] @0x13 -> still stall. x_req[1] @0x13 -> stall=0 next cycle, occupancy 1 -> 0.
- Fill set 3: accept 0x13 and 0x23, both targets 0b01. Addr 0x33 -> stall (set full), occupancy=2. Addr 0x14 (set 4) -> accepted. Retire 0x23 -> 0x33 accepted next cycle into way 1.
- Same-cycle: x_req[0] and x_req[1] clear two different entries while a third snoop allocates in another set -> occupancy goes 2 -> 1 in one step.
- Targets = 0 for addr 0x13 while 0x13 is pending -> no stall, no allocation. Spurious x_req @0x55 -> no state change.
- flush_i with 3 valid entries and a snoop valid -> stall=1 that cycle, occupancy=0 next cycle, same snoop accepted after flush_i drops.
- NumWays=4, IdxWidth=2, NoRespPorts=3: rerun the first and second scenarios. Assert rst_ni low with 5 entries live -> occupancy_o=0 and busy_o=0 immediately.
